// File: rtl/xor_stream_sequencer_pkg.sv
// ============================================================================
// Package  : cipher_pkg
// Brief    : Shared types, constants and helpers for the serial XOR cipher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cipher_pkg;

    localparam int CIPHER_N = 8;
    localparam int c_max_n  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RX   = 1'b1
    } rx_state_t;

    // Rotate the low n bits of word left by one; bits above n stay zero.
    function automatic logic [c_max_n-1:0] rol1(input logic [c_max_n-1:0] word,
                                                input int unsigned         n);
        logic [c_max_n-1:0] mask;
        mask = {c_max_n{1'b1}} >> (c_max_n - n);
        return ((word << 1) | (word >> (n - 1))) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xor_stream_sequencer_if.sv
// ============================================================================
// Interface : xor_stream_sequencer_if
// Brief     : Serial input strobes and cipher output pins of the sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xor_stream_sequencer_if;

    logic start;
    logic d;
    logic key_sel;
    logic q;
    logic q_valid;
    logic key_valid;
    logic busy;
    logic err;

    modport master (
        output start, d, key_sel,
        input  q, q_valid, key_valid, busy, err
    );

    modport slave (
        input  start, d, key_sel,
        output q, q_valid, key_valid, busy, err
    );

endinterface

`default_nettype wire

// File: rtl/xor_stream_sequencer_p2s_shifter.sv
// ============================================================================
// Module   : p2s_shifter
// Brief    : Parallel-in serial-out shifter, MSB first, N valid cycles per load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module p2s_shifter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic         q,
    output logic         q_valid
);

    localparam int                c_cnt_w = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    logic [N-1:0]       r_sr;
    logic [c_cnt_w-1:0] r_left;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_sr    <= din;
            r_left  <= c_last;
            r_valid <= 1'b1;
        end else if (r_valid) begin
            r_sr <= {r_sr[N-2:0], 1'b0};
            if (r_left == '0) begin
                r_valid <= 1'b0;
            end else begin
                r_left <= r_left - 1'b1;
            end
        end
    end

    // Stale bits left after the last shift never reach the pin.
    assign q       = r_valid & r_sr[N-1];
    assign q_valid = r_valid;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        load |-> (!r_valid || r_left == '0));

endmodule

`default_nettype wire

// File: rtl/xor_stream_sequencer.sv
// ============================================================================
// Module   : xor_stream_sequencer
// Brief    : Frames serial words, routes them to key or cipher path, XORs data
//            with the (optionally rolling) key and re-serialises ciphertext.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_stream_sequencer
    import cipher_pkg::*;
#(
    parameter int N    = CIPHER_N,
    parameter bit ROLL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    xor_stream_sequencer_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-2:0]       r_word;
    logic [N-1:0]       r_key;
    logic               r_key_sel;
    logic               r_key_valid;
    logic               r_err;

    logic               w_accept;
    logic               w_last;
    logic [N-1:0]       w_word_full;
    logic [N-1:0]       w_key_next;
    logic               w_load;
    logic [N-1:0]       w_tx_data;
    logic               w_q;
    logic               w_q_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RX;
                end
            end
            RX: begin
                if (r_cnt == c_cnt_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The LSB is still on d during the last cycle, so dispatch uses the
    // assembled word directly and the result is visible one edge later.
    assign w_word_full = {r_word, bus.d};
    assign w_load      = w_last & ~r_key_sel & r_key_valid;
    assign w_tx_data   = w_word_full ^ r_key;

    generate
        if (ROLL) begin : g_roll
            logic [c_max_n-1:0] w_key_ext;
            always_comb begin
                w_key_ext        = '0;
                w_key_ext[N-1:0] = r_key;
            end
            assign w_key_next = N'(rol1(w_key_ext, N));
        end else begin : g_static
            assign w_key_next = r_key;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_word      <= '0;
            r_key       <= '0;
            r_key_sel   <= 1'b0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word    <= {{(N-2){1'b0}}, bus.d};
                r_cnt     <= c_cnt_w'(1);
                r_key_sel <= bus.key_sel;
            end else if (r_state == RX) begin
                r_word <= w_word_full[N-2:0];
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_last) begin
                if (r_key_sel) begin
                    r_key       <= w_word_full;
                    r_key_valid <= 1'b1;
                end else if (r_key_valid) begin
                    r_key <= w_key_next;
                end else begin
                    r_err <= 1'b1;
                end
            end

            // Any start seen mid-frame, including the LSB cycle, is an overrun.
            if (r_state == RX && bus.start) begin
                r_err <= 1'b1;
            end
        end
    end

    p2s_shifter #(
        .N (N)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .din     (w_tx_data),
        .q       (w_q),
        .q_valid (w_q_valid)
    );

    assign bus.q         = w_q;
    assign bus.q_valid   = w_q_valid;
    assign bus.key_valid = r_key_valid;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state == RX) | w_accept | w_q_valid;

endmodule

`default_nettype wire

// File: tb/tb_xor_stream_sequencer.sv
// ============================================================================
// Module   : tb_xor_stream_sequencer
// Brief    : Directed bench for xor_stream_sequencer (N=8, ROLL=0 and ROLL=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_stream_sequencer;

    localparam int c_hist = 1024;

    logic clk = 1'b0;
    logic rst;
    logic r_start;
    logic r_d;
    logic r_key_sel;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    xor_stream_sequencer_if bus0 ();
    xor_stream_sequencer_if bus1 ();

    assign bus0.start = r_start;  assign bus1.start = r_start;
    assign bus0.d = r_d;          assign bus1.d = r_d;
    assign bus0.key_sel = r_key_sel; assign bus1.key_sel = r_key_sel;

    xor_stream_sequencer #(.N(8), .ROLL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    xor_stream_sequencer #(.N(8), .ROLL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic act_q [2], act_v [2], act_kv [2], act_busy [2], act_err [2];
    assign act_q[0] = bus0.q;           assign act_q[1] = bus1.q;
    assign act_v[0] = bus0.q_valid;     assign act_v[1] = bus1.q_valid;
    assign act_kv[0] = bus0.key_valid;  assign act_kv[1] = bus1.key_valid;
    assign act_busy[0] = bus0.busy;     assign act_busy[1] = bus1.busy;
    assign act_err[0] = bus0.err;       assign act_err[1] = bus1.err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic hist_q [2][c_hist];
    logic hist_v [2][c_hist];
    logic hist_kv [2][c_hist];
    logic hist_err [2][c_hist];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: frames are collected as whole words; each ciphertext
    // word becomes a queue of bits that must appear on q one per cycle.
    logic [7:0] m_key [2], m_word [2];
    logic       m_kv [2], m_err [2], m_inf [2], m_sel [2];
    int         m_nb [2];
    bit         m_txq [2][$];
    bit         m_armed = 1'b0;

    always @(negedge clk) begin : model_cmp
        logic       e_v, e_q;
        logic [7:0] ct;
        for (int i = 0; i < 2; i++) begin
            if (cyc < c_hist) begin
                hist_q[i][cyc]   = act_q[i];
                hist_v[i][cyc]   = act_v[i];
                hist_kv[i][cyc]  = act_kv[i];
                hist_err[i][cyc] = act_err[i];
            end
            if (m_armed) begin
                e_v = (m_txq[i].size() != 0);
                e_q = e_v ? m_txq[i][0] : 1'b0;
                check($sformatf("q_valid[%0d]", i), 16'(act_v[i]), 16'(e_v));
                check($sformatf("q[%0d]", i), 16'(act_q[i]), 16'(e_q));
                check($sformatf("key_valid[%0d]", i), 16'(act_kv[i]), 16'(m_kv[i]));
                check($sformatf("err[%0d]", i), 16'(act_err[i]), 16'(m_err[i]));
                check($sformatf("busy[%0d]", i), 16'(act_busy[i]),
                      16'(m_inf[i] | r_start | e_v));
            end
            if (m_txq[i].size() != 0) void'(m_txq[i].pop_front());
            if (rst) begin
                m_key[i] = '0; m_word[i] = '0; m_kv[i] = 0; m_err[i] = 0;
                m_inf[i] = 0;  m_sel[i] = 0;   m_nb[i] = 0; m_txq[i].delete();
            end else if (!m_inf[i]) begin
                if (r_start) begin
                    m_inf[i] = 1; m_word[i] = {7'd0, r_d}; m_nb[i] = 1; m_sel[i] = r_key_sel;
                end
            end else begin
                if (r_start) m_err[i] = 1;
                m_word[i] = {m_word[i][6:0], r_d};
                m_nb[i]++;
                if (m_nb[i] == 8) begin
                    m_inf[i] = 0;
                    if (m_sel[i]) begin
                        m_key[i] = m_word[i]; m_kv[i] = 1;
                    end else if (m_kv[i]) begin
                        ct = m_word[i] ^ m_key[i];
                        for (int b = 7; b >= 0; b--) m_txq[i].push_back(ct[3'(b)]);
                        if (i == 1) m_key[i] = {m_key[i][6:0], m_key[i][7]};
                    end else begin
                        m_err[i] = 1;
                    end
                end
            end
        end
        if (rst) m_armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc > 5000) begin
            $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
            $fatal(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic ks, input int inj, output int t0);
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            r_start   = (k == 0) || (k == inj);
            r_d       = w[3'(7 - k)];
            r_key_sel = (k == 0) ? ks : 1'($urandom_range(1, 0));
            tick();
        end
        r_start = 0; r_d = 0; r_key_sel = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    function automatic logic [7:0] get_byte(input int inst, input int t0);
        logic [7:0] v = '0;
        for (int b = 0; b < 8; b++) v = {v[6:0], hist_q[inst][t0 + b]};
        return v;
    endfunction

    function automatic int count_v(input int inst, input int t0, input int len);
        int n = 0;
        for (int c = t0; c < t0 + len; c++) n += int'(hist_v[inst][c]);
        return n;
    endfunction

    initial begin : stim
        int tk, td, td2;
        rst = 1; r_start = 0; r_d = 0; r_key_sel = 0;
        repeat (3) tick();
        rst = 0;

        // Idle with toggling d and no start.
        for (int k = 0; k < 20; k++) begin r_d = ~r_d; tick(); end
        r_d = 0;
        tick();
        check("idle_kv", 16'(hist_kv[0][cyc-1]), 16'h0);
        check("idle_v_count", 16'(count_v(0, cyc - 21, 21)), 16'd0);

        // Key 0xA5 then back-to-back data 0x3C, 0x3C.
        do_reset();
        send_frame(8'hA5, 1'b1, -1, tk);
        send_frame(8'h3C, 1'b0, -1, td);
        send_frame(8'h3C, 1'b0, -1, td2);
        repeat (12) tick();
        check("kv_before", 16'(hist_kv[0][tk+7]), 16'h0);
        check("kv_rise", 16'(hist_kv[0][tk+8]), 16'h1);
        check("ct0_first", 16'(get_byte(0, td + 8)), 16'h99);
        check("ct0_second", 16'(get_byte(0, td + 16)), 16'h99);
        check("ct1_first", 16'(get_byte(1, td + 8)), 16'h99);
        check("ct1_rolled", 16'(get_byte(1, td + 16)), 16'h77);
        check("v1_continuous", 16'(count_v(1, td + 8, 16)), 16'd16);
        check("v1_before", 16'(hist_v[1][td+7]), 16'h0);
        check("v1_after", 16'(hist_v[1][td+24]), 16'h0);

        // Data frame with no key loaded.
        do_reset();
        send_frame(8'h3C, 1'b0, -1, td);
        repeat (12) tick();
        check("nokey_err_pre", 16'(hist_err[0][td+7]), 16'h0);
        check("nokey_err", 16'(hist_err[0][td+8]), 16'h1);
        check("nokey_no_q", 16'(count_v(0, td, 20)), 16'd0);
        check("nokey_kv", 16'(hist_kv[0][td+19]), 16'h0);

        // Overrun: stray start at bit 3 of a data frame.
        do_reset();
        send_frame(8'hFF, 1'b1, -1, tk);
        send_frame(8'h0F, 1'b0, 3, td);
        repeat (10) tick();
        check("ovr_err_pre", 16'(hist_err[0][td+3]), 16'h0);
        check("ovr_err", 16'(hist_err[0][td+4]), 16'h1);
        check("ovr_ct", 16'(get_byte(0, td + 8)), 16'hF0);
        check("ovr_v", 16'(count_v(0, td + 8, 8)), 16'd8);

        // Reset during bit 5 of ciphertext output.
        do_reset();
        send_frame(8'hA5, 1'b1, -1, tk);
        send_frame(8'h3C, 1'b0, -1, td);
        repeat (5) tick();
        rst = 1; tick(); rst = 0;
        tick();
        send_frame(8'h3C, 1'b0, -1, td2);
        repeat (4) tick();
        check("mid_v_at_rst", 16'(hist_v[0][td+13]), 16'h1);
        check("mid_v_after", 16'(hist_v[0][td+14]), 16'h0);
        check("mid_kv_after", 16'(hist_kv[0][td+14]), 16'h0);
        check("mid_next_err", 16'(hist_err[0][td2+8]), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
